processing_unit: RTL
====================

# processing_unit

Datapath stage for the RISC-SPM core. It sits directly downstream of the control unit and executes that unit's per-cycle load and select strobes. It holds the register file R0–R3, PC, IR, Add_R, Reg_Y and Reg_Z, plus the two bus muxes and the ALU. It feeds `instruction` and `zero` back to the control unit, and presents `address` and `Bus_1` to memory.

## Interface
- `word_size`, 8, datapath and instruction width
- `op_size`, 4, opcode width (`instruction[word_size-1 -: op_size]`)
- `Sel1_size`, 3, Bus_1 mux select width
- `Sel2_size`, 2, Bus_2 mux select width

- `clk` input 1: single clock; all registers update on its rising edge
- `rst` input 1: asynchronous, active-low reset
- `Load_R0`, `Load_R1`, `Load_R2`, `Load_R3` input 1 each: load Rn from Bus_2
- `Load_PC` input 1: load PC from Bus_2
- `Inc_PC` input 1: increment PC
- `Load_IR` input 1: load IR from Bus_2
- `Load_Add_R` input 1: load Add_R from Bus_2
- `Load_Reg_Y` input 1: load Reg_Y from Bus_2
- `Load_Reg_Z` input 1: load Reg_Z with the ALU zero result
- `Sel_Bus_1_Mux` input Sel1_size: Bus_1 source select
- `Sel_Bus_2_Mux` input Sel2_size: Bus_2 source select
- `mem_word` input word_size: memory read data
- `instruction` output word_size: IR contents
- `zero` output 1: Reg_Z contents
- `address` output word_size: Add_R contents, used as the memory address
- `Bus_1` output word_size: combinational Bus_1, also the memory write data

## Operation
- **Bus_1 mux** (combinational). Select values:
  - 0 → R0, 1 → R1, 2 → R2, 3 → R3, 4 → PC
  - 5–7 or X → 0
- **Bus_2 mux** (combinational). Select values:
  - 0 → alu_out, 1 → Bus_1, 2 → mem_word
  - 3 or X → 0
- **ALU** (combinational). Operands: data_1 = Reg_Y, data_2 = Bus_1; opcode = IR[7:4].
  - NOP (0): result 0
  - ADD (1): data_1 + data_2
  - SUB (2): data_2 − data_1
  - AND (3): data_1 & data_2
  - NOT (4): ~data_2
  - Opcodes 5–15: result 0
  - All arithmetic is mod 2^word_size; carry and borrow are discarded.
- **alu_zero** = (alu_out == 0).
- **Register loads.** Each register loads independently on its own strobe. Several strobes may be asserted in the same cycle, and every selected register takes the same Bus_2 value.
- **PC update priority:**
  - `Load_PC` beats `Inc_PC`.
  - `Inc_PC` alone: PC ← PC+1, wrapping 0xFF → 0x00.
  - Neither: PC holds.
- **Reg_Z.** Loads alu_zero only when `Load_Reg_Z` is asserted; otherwise it holds.
- **Same-edge read/write.** Loads sample Bus_2 as it stands before the edge. Example: with `Load_Add_R` and `Inc_PC` asserted together and Bus_1 = PC, Add_R gets the old PC and PC gets old+1.
- **Single-cycle operations.** A register can be both read and written in the same cycle (e.g. R1 ← ~R1). This must work with no combinational loop, because all storage is edge-triggered.
- No state machine is required. Sequencing is owned entirely by the control unit; this block has no handshake.

## Timing
- **Reset.** `rst` low immediately forces R0–R3, PC, IR, Add_R, Reg_Y and Reg_Z to 0. Therefore `instruction` = 0, `zero` = 0, `address` = 0.
  - `Bus_1` then reflects the select value applied to zeroed registers, i.e. 0 for every select value.
  - Asserting reset mid-instruction discards all partial state. No load takes effect on the edge where `rst` is low.
- **Release.** Registers resume on the first rising edge after `rst` goes high.
- **Latency:**
  - Strobe to register output: 1 cycle.
  - `Bus_1` and the Bus_2/ALU path are zero-cycle combinational from register outputs and selects.
  - `mem_word` → Bus_2 is combinational. Memory must present data in the same cycle as `address`.
- **Fetch pattern seen by this block:**
  - Cycle n: Bus_1=PC, Bus_2=Bus_1, `Load_Add_R`.
  - Cycle n+1: Bus_2=mem_word, `Load_IR`, `Inc_PC`.
  - `instruction` is valid from cycle n+2.

## Test plan
- **Reset:** hold `rst`=0 with all strobes high and `mem_word`=0xAA → every output reads 0 throughout. Release, then `Inc_PC` for 3 cycles → PC=3.
- **Fetch:** PC=0x10, `mem_word`=0x16, apply the fetch pattern → Add_R=0x10, IR=0x16, PC=0x11 two edges later.
- **ADD:**
  - Setup: R1=0x05, R2=0xFF, IR=0x16 (ADD src R1, dest R2).
  - Sequence: Reg_Y←Bus_1(R1), then Sel_Bus_1=2, Sel_Bus_2=0, `Load_R2`, `Load_Reg_Z`.
  - Result: R2=0x04, zero=0.
- **SUB to zero:** R0=R3=0x3C, IR=0x23, same sequence → R3=0x00, zero=1.
- **NOT:** IR=0x40 with R0=0x0F, Sel_Bus_1=0, Sel_Bus_2=0, `Load_R0`+`Load_Reg_Z` in one cycle → R0=0xF0, zero=0.
- **PC edges:**
  - PC=0xFF with `Inc_PC` → 0x00.
  - `Load_PC`+`Inc_PC` with Bus_2=mem_word=0x42 → PC=0x42.
  - Sel_Bus_1=6 → Bus_1=0.
  - `rst` pulsed low mid-sequence → all registers 0 without waiting for a clock edge.

Source files
------------

// File: rtl/processing_unit.sv
// ============================================================================
// Module   : processing_unit
// Brief    : RISC-SPM datapath: register file, PC, IR, Add_R, Reg_Y, Reg_Z,
//            the two bus muxes and the ALU, driven by control-unit strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module processing_unit #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load_R0,
    input  logic                 Load_R1,
    input  logic                 Load_R2,
    input  logic                 Load_R3,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    input  logic                 Load_IR,
    input  logic                 Load_Add_R,
    input  logic                 Load_Reg_Y,
    input  logic                 Load_Reg_Z,
    input  logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    input  logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    input  logic [word_size-1:0] mem_word,
    output logic [word_size-1:0] instruction,
    output logic                 zero,
    output logic [word_size-1:0] address,
    output logic [word_size-1:0] Bus_1
);

    localparam logic [op_size-1:0] c_op_nop = op_size'(0);
    localparam logic [op_size-1:0] c_op_add = op_size'(1);
    localparam logic [op_size-1:0] c_op_sub = op_size'(2);
    localparam logic [op_size-1:0] c_op_and = op_size'(3);
    localparam logic [op_size-1:0] c_op_not = op_size'(4);

    localparam logic [Sel1_size-1:0] c_b1_r0 = Sel1_size'(0);
    localparam logic [Sel1_size-1:0] c_b1_r1 = Sel1_size'(1);
    localparam logic [Sel1_size-1:0] c_b1_r2 = Sel1_size'(2);
    localparam logic [Sel1_size-1:0] c_b1_r3 = Sel1_size'(3);
    localparam logic [Sel1_size-1:0] c_b1_pc = Sel1_size'(4);

    localparam logic [Sel2_size-1:0] c_b2_alu = Sel2_size'(0);
    localparam logic [Sel2_size-1:0] c_b2_b1  = Sel2_size'(1);
    localparam logic [Sel2_size-1:0] c_b2_mem = Sel2_size'(2);

    localparam logic [word_size-1:0] c_zero_word = '0;
    localparam logic [word_size-1:0] c_one_word  = word_size'(1);

    logic [word_size-1:0] r_reg [0:3];
    logic [word_size-1:0] r_pc;
    logic [word_size-1:0] r_ir;
    logic [word_size-1:0] r_add_r;
    logic [word_size-1:0] r_reg_y;
    logic                 r_reg_z;

    logic [3:0]           w_load_r;
    logic [word_size-1:0] w_bus_1;
    logic [word_size-1:0] w_bus_2;
    logic [word_size-1:0] w_alu_out;
    logic                 w_alu_zero;
    logic [op_size-1:0]   w_opcode;

    assign w_load_r = {Load_R3, Load_R2, Load_R1, Load_R0};
    assign w_opcode = r_ir[word_size-1 -: op_size];

    // Bus_1: register/PC source; unused or unknown selects drive zero.
    always_comb begin
        w_bus_1 = c_zero_word;
        case (Sel_Bus_1_Mux)
            c_b1_r0: w_bus_1 = r_reg[0];
            c_b1_r1: w_bus_1 = r_reg[1];
            c_b1_r2: w_bus_1 = r_reg[2];
            c_b1_r3: w_bus_1 = r_reg[3];
            c_b1_pc: w_bus_1 = r_pc;
            default: w_bus_1 = c_zero_word;
        endcase
    end

    always_comb begin
        w_bus_2 = c_zero_word;
        case (Sel_Bus_2_Mux)
            c_b2_alu: w_bus_2 = w_alu_out;
            c_b2_b1:  w_bus_2 = w_bus_1;
            c_b2_mem: w_bus_2 = mem_word;
            default:  w_bus_2 = c_zero_word;
        endcase
    end

    // ALU: data_1 = Reg_Y, data_2 = Bus_1; results wrap, carry/borrow dropped.
    always_comb begin
        w_alu_out = c_zero_word;
        case (w_opcode)
            c_op_nop: w_alu_out = c_zero_word;
            c_op_add: w_alu_out = r_reg_y + w_bus_1;
            c_op_sub: w_alu_out = w_bus_1 - r_reg_y;
            c_op_and: w_alu_out = r_reg_y & w_bus_1;
            c_op_not: w_alu_out = ~w_bus_1;
            default:  w_alu_out = c_zero_word;
        endcase
    end

    assign w_alu_zero = (w_alu_out == c_zero_word);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg_file
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_reg[gi] <= c_zero_word;
                end else if (w_load_r[gi]) begin
                    r_reg[gi] <= w_bus_2;
                end
            end
        end
    endgenerate

    // Load_PC takes priority over Inc_PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= c_zero_word;
        end else if (Load_PC) begin
            r_pc <= w_bus_2;
        end else if (Inc_PC) begin
            r_pc <= r_pc + c_one_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir    <= c_zero_word;
            r_add_r <= c_zero_word;
            r_reg_y <= c_zero_word;
            r_reg_z <= 1'b0;
        end else begin
            if (Load_IR)    r_ir    <= w_bus_2;
            if (Load_Add_R) r_add_r <= w_bus_2;
            if (Load_Reg_Y) r_reg_y <= w_bus_2;
            if (Load_Reg_Z) r_reg_z <= w_alu_zero;
        end
    end

    assign instruction = r_ir;
    assign zero        = r_reg_z;
    assign address     = r_add_r;
    assign Bus_1       = w_bus_1;

endmodule

`default_nettype wire
